ccff_bitstream_loader: RTL

- Upstream feeder for the configuration-chain flops (ccff) of the switch/connection blocks.
- Accepts bitstream words over a valid/ready stream, serializes them MSB-first onto ccff_head, and generates a per-cycle shift enable for the chain's clock gate.
- Tracks the total shift count and raises done once exactly CHAIN_LEN bits sit in the chain.
- An optional marker/loopback check confirms the chain length via ccff_tail.

---
 rtl/ccff_bitstream_loader_if.sv | 22 ++
 rtl/ccff_bitstream_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader_if.sv
// ccff_bitstream_loader_if: valid/ready bitstream word stream feeding the
// configuration-chain loader. The master drives words, the slave (loader)
// drives s_ready.
interface ccff_bitstream_loader_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready
   );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: accepts bitstream words over a valid/ready stream and
// serializes them MSB-first onto ccff_head, pairing every bit with a registered
// ccff_shift_en for the chain clock gate. done rises once exactly the target
// number of shift events has occurred.
// Build macro CCFF_LOOPBACK_CHECK_EN: prepends the marker 8'hA5 before the
// bitstream and checks it as it leaves the chain on ccff_tail (sticky error).
module ccff_bitstream_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic                   prog_clk,
   input  logic                   prog_rst_n,
   input  logic                   start,
   ccff_bitstream_loader_if.slave s_bus,
   output logic                   ccff_head,
   output logic                   ccff_shift_en,
   input  logic                   ccff_tail,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);
   localparam int IDX_W = (DATA_W > 8) ? $clog2(DATA_W) : 3;
`ifdef CCFF_LOOPBACK_CHECK_EN
   localparam int MK_LEN = 8;
`else
   localparam int MK_LEN = 0;
`endif
   localparam logic [CNT_W-1:0] TARGET = CNT_W'(CHAIN_LEN + MK_LEN);
   localparam logic [7:0]       MARKER = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MARKER = 3'd1,
      ST_FETCH  = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   state_t             w_first_state;
   logic [DATA_W-1:0]  r_sreg;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_next;
   logic [CNT_W-1:0]   r_total;      // shift events seen by the chain
   logic [CNT_W-1:0]   w_issued;     // bits handed to the chain (incl. one in flight)
   logic               r_head;
   logic               r_shift_en;
   logic               r_s_ready;
   logic               r_busy;
   logic               r_done;
   logic               w_issue;
   logic               w_bit;
   logic               w_load;
   logic               w_clear;

   // A bit registered on ccff_head is shifted one edge later, so it is already
   // committed and must be counted when deciding whether to issue another.
   assign w_issued = r_total + CNT_W'(r_shift_en);

`ifdef CCFF_LOOPBACK_CHECK_EN
   assign w_first_state = ST_MARKER;
`else
   assign w_first_state = ST_FETCH;
`endif

   // State register.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode plus per-cycle issue/load decisions.
   always_comb begin
      w_next_state = r_state;
      w_idx_next   = r_idx;
      w_issue      = 1'b0;
      w_bit        = 1'b0;
      w_load       = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_clear      = 1'b1;
               w_next_state = w_first_state;
               w_idx_next   = IDX_W'(7);
            end else begin
               w_next_state = r_state;
            end
         end
         ST_MARKER: begin
            w_issue = 1'b1;
            w_bit   = MARKER[r_idx[2:0]];
            if (r_idx == {IDX_W{1'b0}}) begin
               w_next_state = ST_FETCH;
            end else begin
               w_idx_next = r_idx - IDX_W'(1);
            end
         end
         ST_FETCH: begin
            if (s_bus.s_valid && r_s_ready) begin
               w_load       = 1'b1;
               w_idx_next   = IDX_W'(DATA_W - 1);
               w_next_state = ST_SHIFT;
            end else begin
               w_next_state = ST_FETCH;
            end
         end
         ST_SHIFT: begin
            if (w_issued >= TARGET) begin
               // Last bit is on the wire this cycle; its shift event ends the load.
               w_next_state = ST_DONE;
            end else begin
               w_issue = 1'b1;
               w_bit   = r_sreg[r_idx];
               if ((w_issued + CNT_W'(1)) == TARGET) begin
                  // Remaining LSBs of this word are discarded.
                  w_next_state = ST_SHIFT;
               end else if (r_idx == {IDX_W{1'b0}}) begin
                  w_next_state = ST_FETCH;
               end else begin
                  w_idx_next = r_idx - IDX_W'(1);
               end
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Datapath, shift counter and registered outputs.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         r_sreg     <= {DATA_W{1'b0}};
         r_idx      <= {IDX_W{1'b0}};
         r_total    <= {CNT_W{1'b0}};
         r_head     <= 1'b0;
         r_shift_en <= 1'b0;
         r_s_ready  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_idx      <= w_idx_next;
         r_head     <= w_bit;
         r_shift_en <= w_issue;
         r_s_ready  <= (w_next_state == ST_FETCH);
         r_busy     <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
         r_done     <= (w_next_state == ST_DONE);
         if (w_load) begin
            r_sreg <= s_bus.s_data;
         end else begin
            r_sreg <= r_sreg;
         end
         if (w_clear) begin
            r_total <= {CNT_W{1'b0}};
         end else if (r_shift_en) begin
            r_total <= r_total + CNT_W'(1);
         end else begin
            r_total <= r_total;
         end
      end
   end

`ifdef CCFF_LOOPBACK_CHECK_EN
   logic [CNT_W-1:0] w_k;
   logic [2:0]       w_pos;
   logic             w_mk_bit;
   logic             r_error;

   // w_k is the 1-based index of the shift event happening at this edge;
   // events CHAIN_LEN+1..CHAIN_LEN+8 see the marker on ccff_tail, MSB first.
   assign w_k      = r_total + CNT_W'(1);
   assign w_pos    = 3'(TARGET - w_k);
   assign w_mk_bit = MARKER[w_pos];

   // Sticky loopback mismatch flag, cleared by a new start.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         r_error <= 1'b0;
      end else if (w_clear) begin
         r_error <= 1'b0;
      end else if (r_shift_en && (w_k > CNT_W'(CHAIN_LEN)) && (w_k <= TARGET)
                   && (ccff_tail != w_mk_bit)) begin
         r_error <= 1'b1;
      end else begin
         r_error <= r_error;
      end
   end

   assign error = r_error;
`else
   logic w_unused_tail;
   assign w_unused_tail = ccff_tail;
   assign error         = 1'b0;
`endif

   assign s_bus.s_ready = r_s_ready;
   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shift_en;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule
